// File: rtl/aes256_cbc_framer_if.sv
// AXI4-Stream style byte interface shared by the framer's input and output.
// A beat transfers on a rising edge where tvalid && tready are both high;
// the master keeps tvalid and its payload stable until that edge.
interface axis_if;
    logic [7:0] tdata;
    logic       tvalid;
    logic       tready;
    logic       tlast;
    logic       tuser;
    logic       tkeep;

    modport master (output tdata, output tvalid, output tlast, output tuser, output tkeep,
                    input  tready);
    modport slave  (input  tdata, input  tvalid, input  tlast, input  tuser, input  tkeep,
                    output tready);
endinterface

// File: rtl/aes256_cbc_framer.sv
// aes256_cbc_framer: serialises an AES-256 CBC request for a byte-wide core.
// Each request is 16 beats of Key[127:0], 16 beats of Key[255:128], 16 beats
// of Iv, then the message bytes, padded out to a whole 16-byte block.
//
// Build option AES_CBC_FRAMER_PKCS7_EN:
//   defined   - PKCS#7 padding (a full pad block when the message already
//               ends on a block boundary); Pad_err is tied low.
//   undefined - a short final block is zero-filled and Pad_err pulses when
//               the last message byte is accepted.
//
// Handshake rule on both streams: a beat moves on the rising edge where
// tvalid && tready; the sender holds tvalid, tdata, tlast and tuser steady
// until then. State_dbg exposes the one-hot FSM state for checkers.
module aes256_cbc_framer (
    input  logic         Clk,
    input  logic         Rst,
    input  logic [255:0] Key,
    input  logic [127:0] Iv,
    input  logic         Enc,
    input  logic         Start,
    output logic         Busy,
    output logic         Done,
    output logic         Pad_err,
    axis_if.slave        S_axis,
    axis_if.master       M_axis,
    output logic [5:0]   State_dbg
);

    typedef enum logic [5:0] {
        ST_IDLE  = 6'b000001,
        ST_KEY_0 = 6'b000010,
        ST_KEY_1 = 6'b000100,
        ST_IV    = 6'b001000,
        ST_TEXT  = 6'b010000,
        ST_PAD   = 6'b100000
    } state_t;

    state_t       state_q;
    state_t       state_d;
    logic [3:0]   cnt_q;
    logic [3:0]   cnt_d;
    logic [255:0] key_q;
    logic [127:0] iv_q;
    logic         enc_q;
    logic         done_q;

    logic [127:0] hdr_word;
    logic [7:0]   hdr_byte;
    logic [7:0]   pad_byte;
    logic         m_valid;
    logic [7:0]   m_data;
    logic         m_last;
    logic         s_ready;
    logic         final_hs;

`ifdef AES_CBC_FRAMER_PKCS7_EN
    logic [7:0]   pad_q;
    logic [7:0]   pad_d;
`else
    logic         pad_err_c;
`endif

    // Sideband bits on the message stream carry nothing for this block.
    logic unused_s_side;
    assign unused_s_side = ^{S_axis.tuser, S_axis.tkeep};

    // Header byte select: pick the 128-bit word for the current header state,
    // then the byte addressed by the beat counter (LSB first).
    always_comb begin
        hdr_word = iv_q;
        case (state_q)
            ST_KEY_0: hdr_word = key_q[127:0];
            ST_KEY_1: hdr_word = key_q[255:128];
            default:  hdr_word = iv_q;
        endcase
        hdr_byte = hdr_word[{cnt_q, 3'b000} +: 8];
    end

`ifdef AES_CBC_FRAMER_PKCS7_EN
    assign pad_byte = pad_q;
`else
    assign pad_byte = 8'h00;
`endif

    // Next-state, beat counter and stream outputs.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        m_valid  = 1'b0;
        m_data   = 8'h00;
        m_last   = 1'b0;
        s_ready  = 1'b0;
        final_hs = 1'b0;
`ifdef AES_CBC_FRAMER_PKCS7_EN
        pad_d    = pad_q;
`else
        pad_err_c = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                cnt_d = 4'd0;
                if (Start) begin
                    state_d = ST_KEY_0;
                end
            end
            ST_KEY_0, ST_KEY_1, ST_IV: begin
                m_valid = 1'b1;
                m_data  = hdr_byte;
                if (M_axis.tready) begin
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q == 4'd15) begin
                        if (state_q == ST_KEY_0) begin
                            state_d = ST_KEY_1;
                        end else if (state_q == ST_KEY_1) begin
                            state_d = ST_IV;
                        end else begin
                            state_d = ST_TEXT;
                        end
                    end
                end
            end
            ST_TEXT: begin
                // Zero-latency pass-through; a missing input beat stalls the output.
                m_valid = S_axis.tvalid;
                m_data  = S_axis.tdata;
                s_ready = M_axis.tready;
`ifdef AES_CBC_FRAMER_PKCS7_EN
                m_last  = 1'b0;
`else
                m_last  = S_axis.tlast && (cnt_q == 4'd15);
`endif
                if (S_axis.tvalid && M_axis.tready) begin
                    cnt_d = cnt_q + 4'd1;
                    if (S_axis.tlast) begin
`ifdef AES_CBC_FRAMER_PKCS7_EN
                        // Pad length 15-k; a block-aligned message gets 16 x 8'h10.
                        state_d = ST_PAD;
                        if (cnt_q == 4'd15) begin
                            pad_d = 8'h10;
                        end else begin
                            pad_d = {4'h0, 4'd15 - cnt_q};
                        end
`else
                        if (cnt_q == 4'd15) begin
                            state_d  = ST_IDLE;
                            final_hs = 1'b1;
                        end else begin
                            state_d   = ST_PAD;
                            pad_err_c = 1'b1;
                        end
`endif
                    end
                end
            end
            ST_PAD: begin
                m_valid = 1'b1;
                m_data  = pad_byte;
                m_last  = (cnt_q == 4'd15);
                if (M_axis.tready) begin
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q == 4'd15) begin
                        state_d  = ST_IDLE;
                        final_hs = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // State, counter and holding registers; reset abandons any request.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            key_q   <= '0;
            iv_q    <= '0;
            enc_q   <= 1'b0;
            done_q  <= 1'b0;
`ifdef AES_CBC_FRAMER_PKCS7_EN
            pad_q   <= 8'h00;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= final_hs;
`ifdef AES_CBC_FRAMER_PKCS7_EN
            pad_q   <= pad_d;
`endif
            if ((state_q == ST_IDLE) && Start) begin
                key_q <= Key;
                iv_q  <= Iv;
                enc_q <= Enc;
            end
        end
    end

    // Busy covers the whole request including the Done cycle.
    assign Busy      = (state_q != ST_IDLE) || done_q;
    assign Done      = done_q;
    assign State_dbg = state_q;

`ifdef AES_CBC_FRAMER_PKCS7_EN
    assign Pad_err = 1'b0;
`else
    assign Pad_err = pad_err_c;
`endif

    assign M_axis.tvalid = m_valid;
    assign M_axis.tdata  = m_data;
    assign M_axis.tlast  = m_last;
    assign M_axis.tuser  = enc_q;
    assign M_axis.tkeep  = m_valid;
    assign S_axis.tready = s_ready;

endmodule

// File: tb/tb_aes256_cbc_framer.sv
// Testbench for aes256_cbc_framer: directed requests with a reference model
// feeding an expected-beat queue; a negedge monitor pops and compares.
module tb_aes256_cbc_framer;

`ifdef AES_CBC_FRAMER_PKCS7_EN
    localparam bit PKCS7 = 1'b1;
`else
    localparam bit PKCS7 = 1'b0;
`endif
    localparam logic [5:0] ST_IDLE_V  = 6'b000001;
    localparam logic [5:0] ST_KEY_0_V = 6'b000010;

    logic         Clk = 1'b0;
    logic         Rst;
    logic [255:0] Key;
    logic [127:0] Iv;
    logic         Enc;
    logic         Start;
    logic         Busy;
    logic         Done;
    logic         Pad_err;
    logic [5:0]   State_dbg;

    axis_if s_axis ();
    axis_if m_axis ();

    aes256_cbc_framer dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .Key       (Key),
        .Iv        (Iv),
        .Enc       (Enc),
        .Start     (Start),
        .Busy      (Busy),
        .Done      (Done),
        .Pad_err   (Pad_err),
        .S_axis    (s_axis),
        .M_axis    (m_axis),
        .State_dbg (State_dbg)
    );

    // Clock / cycle counter
    always #5 Clk = ~Clk;

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    // Scoreboard state: {tlast, tuser, tdata}
    logic [9:0] exp_q[$];
    int         n_checks = 0;
    int         n_pass   = 0;
    int         last_hs_cyc = 0;
    bit         held_stall = 1'b0;
    logic [9:0] held_word = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Output monitor: stability under backpressure, tkeep, and beat compare.
    always @(negedge Clk) begin
        logic [9:0] obs;
        logic [9:0] exp;
        obs = {m_axis.tlast, m_axis.tuser, m_axis.tdata};
        if (held_stall && m_axis.tvalid) check("hold_stable", obs, held_word);
        held_stall = m_axis.tvalid && !m_axis.tready;
        held_word  = obs;
        if (m_axis.tvalid) check("tkeep", m_axis.tkeep, 1);
        if (m_axis.tvalid && m_axis.tready) begin
            last_hs_cyc = cyc;
            n_checks++;
            assert (exp_q.size() != 0) n_pass++;
            else $error("FAIL beat_unexpected observed=%0h expected=none", obs);
            if (exp_q.size() != 0) begin
                exp = exp_q.pop_front();
                check("m_beat", obs, exp);
            end
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic rand_key(output logic [255:0] k, output logic [127:0] v);
        for (int i = 0; i < 8; i++) k[32*i +: 32] = $urandom;
        for (int i = 0; i < 4; i++) v[32*i +: 32] = $urandom;
    endtask

    // One request: model -> exp_q, then drive Start, S stream and M.tready.
    // abort_at > 0 asserts Rst after that many message bytes were accepted.
    task automatic run_req(input logic [255:0] k, input logic [127:0] v, input logic enc,
                           input int len, input bit rnd_data, input bit rnd, input int abort_at);
        logic [7:0] msg[$];
        logic [7:0] text[$];
        int         kk;
        int         p;
        int         exp_pad_err;
        int         idx;
        int         pad_cnt;
        bit         done_seen;
        bit         s_hs;
        bit         aborted;

        for (int i = 0; i < len; i++) msg.push_back(rnd_data ? 8'($urandom) : 8'(8'h61 + i));
        text = msg;
        kk = (len - 1) % 16;
        exp_pad_err = 0;
        if (PKCS7) begin
            p = 15 - kk;
            if (p == 0) p = 16;
            for (int i = 0; i < p; i++) text.push_back(8'(p));
        end else if (kk < 15) begin
            for (int i = 0; i < 15 - kk; i++) text.push_back(8'h00);
            exp_pad_err = 1;
        end
        for (int i = 0; i < 32; i++) exp_q.push_back({1'b0, enc, k[8*i +: 8]});
        for (int i = 0; i < 16; i++) exp_q.push_back({1'b0, enc, v[8*i +: 8]});
        for (int i = 0; i < text.size(); i++)
            exp_q.push_back({(i == text.size() - 1), enc, text[i]});

        Key = k; Iv = v; Enc = enc; Start = 1'b1;
        m_axis.tready = 1'b1;
        tick();
        Start = 1'b0; Key = ~k; Iv = ~v; Enc = ~enc;
        check("busy_rise", Busy, 1);
        check("state_key0", State_dbg, ST_KEY_0_V);

        idx = 0; pad_cnt = 0; done_seen = 0; s_hs = 0; aborted = 0;
        for (int c = 0; c < 3000 && !done_seen; c++) begin
            if (abort_at > 0 && idx == abort_at) begin
                aborted = 1'b1;
                break;
            end
            m_axis.tready = rnd ? ($urandom_range(0, 99) >= 30) : 1'b1;
            Start = (c == 5);
            if (s_hs) s_axis.tvalid = 1'b0;
            if (!s_axis.tvalid && idx < len && (!rnd || $urandom_range(0, 3) != 0)) begin
                s_axis.tvalid = 1'b1;
                s_axis.tdata  = msg[idx];
                s_axis.tlast  = (idx == len - 1);
            end
            @(negedge Clk);
            if (Pad_err) pad_cnt++;
            if (Done) begin
                done_seen = 1'b1;
                check("done_latency", cyc - last_hs_cyc, 1);
                check("busy_at_done", Busy, 1);
            end
            s_hs = s_axis.tvalid && s_axis.tready;
            if (s_hs) idx++;
            @(posedge Clk);
            #1;
        end
        Start = 1'b0;
        s_axis.tvalid = 1'b0;
        s_axis.tlast  = 1'b0;

        if (aborted) begin
            Rst = 1'b1;
            m_axis.tready = 1'b1;
            tick();
            Rst = 1'b0;
            exp_q.delete();
            @(negedge Clk);
            check("rst_state", State_dbg, ST_IDLE_V);
            check("rst_m_tvalid", m_axis.tvalid, 0);
            check("rst_s_tready", s_axis.tready, 0);
            check("rst_busy", Busy, 0);
            check("rst_done", Done, 0);
            tick();
        end else begin
            check("done_seen", done_seen, 1);
            check("bytes_taken", idx, len);
            check("pad_err_count", pad_cnt, exp_pad_err);
            check("queue_drained", exp_q.size(), 0);
            tick();
            check("busy_fall", Busy, 0);
            check("done_pulse", Done, 0);
            check("idle_after", State_dbg, ST_IDLE_V);
        end
    endtask

    // Directed sequence
    initial begin
        logic [255:0] k;
        logic [127:0] v;

        Rst = 1'b1; Start = 1'b0; Key = '0; Iv = '0; Enc = 1'b0;
        s_axis.tvalid = 1'b0; s_axis.tdata = 8'h00; s_axis.tlast = 1'b0;
        s_axis.tuser = 1'b0; s_axis.tkeep = 1'b0;
        m_axis.tready = 1'b1;
        repeat (3) tick();
        @(negedge Clk);
        check("reset_state", State_dbg, ST_IDLE_V);
        check("reset_busy", Busy, 0);
        check("reset_done", Done, 0);
        check("reset_pad_err", Pad_err, 0);
        check("reset_m_tvalid", m_axis.tvalid, 0);
        check("reset_s_tready", s_axis.tready, 0);
        tick();
        Rst = 1'b0;
        tick();

        // Reference vector header, 5-byte message 61..65
        for (int i = 0; i < 32; i++) k[8*i +: 8] = 8'(i);
        for (int i = 0; i < 16; i++) v[8*i +: 8] = 8'(8'hA0 + i);
        run_req(k, v, 1'b1, 5, 1'b0, 1'b0, 0);

        // Block-aligned message, decrypt
        rand_key(k, v);
        run_req(k, v, 1'b0, 16, 1'b0, 1'b0, 0);

        // Short 3-byte message
        rand_key(k, v);
        run_req(k, v, 1'b1, 3, 1'b0, 1'b0, 0);

        // Random data, random M.tready and S gaps
        rand_key(k, v);
        run_req(k, v, 1'b0, 37, 1'b1, 1'b1, 0);

        // Reset mid-text after 20 bytes, then a clean request
        rand_key(k, v);
        run_req(k, v, 1'b1, 40, 1'b1, 1'b0, 20);
        for (int i = 0; i < 32; i++) k[8*i +: 8] = 8'(8'h40 + i);
        for (int i = 0; i < 16; i++) v[8*i +: 8] = 8'(8'hC0 + i);
        run_req(k, v, 1'b1, 20, 1'b0, 1'b0, 0);

        // Start together with Rst: reset wins
        Start = 1'b1; Rst = 1'b1; Key = k;
        tick();
        Start = 1'b0; Rst = 1'b0;
        @(negedge Clk);
        check("start_rst_state", State_dbg, ST_IDLE_V);
        check("start_rst_busy", Busy, 0);
        check("start_rst_m_tvalid", m_axis.tvalid, 0);
        tick();

        // Two-block message under backpressure
        rand_key(k, v);
        run_req(k, v, 1'b0, 32, 1'b1, 1'b1, 0);

        // One-byte message at full rate
        rand_key(k, v);
        run_req(k, v, 1'b1, 1, 1'b1, 1'b0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
